// File: rtl/readout_pkg.sv
// readout_pkg: shared state encoding, header marker and default widths for readout_ctrl
package readout_pkg;
  localparam int DATBITS_DEF = 24;
  localparam int ADDBITS_DEF = 8;
  localparam logic [7:0] HDR_MARK = 8'hA5;
  typedef enum logic [2:0] {ACQ, HDR, RD_ADDR, RD_HOLD, DONE} state_t;
endpackage

// File: rtl/readout_ctrl.sv
// readout_ctrl: buffer write/read sequencer; acquires words, then streams them out over valid/ready (READOUT_HEADER_EN adds a header word; ports: din*, dout*, buffer we/waddr/wdata/rd/raddr/rdata, count/busy/overflow/done)
module readout_ctrl
  import readout_pkg::*;
#(
  parameter int DATBITS = DATBITS_DEF,
  parameter int ADDBITS = ADDBITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic [DATBITS-1:0] din,
  input  logic               readout_req,
  output logic [DATBITS-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               we,
  output logic [ADDBITS-1:0] waddr,
  output logic [DATBITS-1:0] wdata,
  output logic               rd,
  output logic [ADDBITS-1:0] raddr,
  input  logic [DATBITS-1:0] rdata,
  output logic [ADDBITS:0]   count,
  output logic               busy,
  output logic               overflow,
  output logic               done
);
  localparam logic [ADDBITS:0] DEPTH = {1'b1, {ADDBITS{1'b0}}};
  state_t state, state_d;
  logic [ADDBITS:0] count_d, cnt_eff;
  logic [ADDBITS-1:0] ptr, ptr_d, waddr_d, raddr_d;
  logic [DATBITS-1:0] dout_d, wdata_d;
  logic dout_valid_d, we_d, rd_d, overflow_d, done_d, wr;
`ifdef READOUT_HEADER_EN
  logic [DATBITS-9:0] hdr_f;
`endif
  always_comb begin
    wr = state == ACQ && din_valid && count != DEPTH;
    cnt_eff = count + (ADDBITS+1)'(wr);
    state_d = state;
    count_d = count;
    ptr_d = ptr;
    dout_d = dout;
    dout_valid_d = dout_valid;
    we_d = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    rd_d = 1'b0;
    raddr_d = raddr;
    overflow_d = overflow | (din_valid && !wr);
    done_d = 1'b0;
`ifdef READOUT_HEADER_EN
    hdr_f = (DATBITS-8)'(cnt_eff);
    hdr_f[DATBITS-9] = overflow_d;
`endif
    case (state)
      ACQ: begin
        if (wr) begin
          we_d = 1'b1;
          waddr_d = count[ADDBITS-1:0];
          wdata_d = din;
          count_d = cnt_eff;
        end
        if (readout_req) begin
          ptr_d = '0;
`ifdef READOUT_HEADER_EN
          state_d = HDR;
          dout_d = {HDR_MARK, hdr_f};
          dout_valid_d = 1'b1;
`else
          state_d = cnt_eff == '0 ? DONE : RD_ADDR;
          done_d = cnt_eff == '0;
          // a write issued on the same edge holds rd off for one cycle so the buffer never sees rd and we together
          rd_d = cnt_eff != '0 && !wr;
          raddr_d = '0;
`endif
        end
      end
      HDR: if (dout_ready) begin
        dout_valid_d = 1'b0;
        state_d = count == '0 ? DONE : RD_ADDR;
        done_d = count == '0;
        rd_d = count != '0;
        raddr_d = '0;
      end
      RD_ADDR: begin
        rd_d = !rd;
        state_d = rd ? RD_HOLD : RD_ADDR;
        dout_d = rd ? rdata : dout;
        dout_valid_d = rd;
      end
      RD_HOLD: if (dout_ready) begin
        dout_valid_d = 1'b0;
        if ({1'b0, ptr} == count - (ADDBITS+1)'(1)) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          state_d = RD_ADDR;
          ptr_d = ptr + ADDBITS'(1);
          raddr_d = ptr + ADDBITS'(1);
          rd_d = 1'b1;
        end
      end
      DONE: begin
        state_d = ACQ;
        count_d = '0;
        overflow_d = din_valid;
      end
      default: state_d = ACQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ACQ;
      count <= '0;
      ptr <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      rd <= 1'b0;
      raddr <= '0;
      busy <= 1'b0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      ptr <= ptr_d;
      dout <= dout_d;
      dout_valid <= dout_valid_d;
      we <= we_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
      rd <= rd_d;
      raddr <= raddr_d;
      busy <= state_d != ACQ;
      overflow <= overflow_d;
      done <= done_d;
    end
endmodule

// File: doc/readout_ctrl.md
# readout_ctrl

Sequencer that owns the readout buffer's write and read ports. In acquisition it writes incoming data words to consecutive buffer addresses. On a readout request it walks the stored words out through a valid/ready handshake to the downstream consumer (serializer/UART), then re-arms. It sits between the DAQ front end and the buffer, and the buffer is instantiated beside it in the parent.

## Interface
- DATBITS, 24, data word width; matches the buffer
- ADDBITS, 8, buffer address width; depth is 2**ADDBITS words
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- din_valid  in  1  front-end word strobe, one word per cycle
- din  in  DATBITS  front-end data
- readout_req  in  1  start readout; level sampled only in ACQ
- dout  out  DATBITS  readout word to consumer
- dout_valid  out  1  dout holds a word
- dout_ready  in  1  consumer accepts dout
- we, waddr[ADDBITS], wdata[DATBITS]  out  buffer write port
- rd, raddr[ADDBITS]  out  buffer read port
- rdata  in  DATBITS  buffer read data, combinational from rd/raddr
- count  out  ADDBITS+1  words stored
- busy  out  1  high in every state except ACQ
- overflow  out  1  sticky: a din word was dropped
- done  out  1  one-cycle pulse at readout completion

## Operation
- States: ACQ, RD_ADDR, RD_HOLD, DONE.
- Reset values: state=ACQ, count=0, ptr=0, and every output 0.
- ACQ write path:
  - din_valid with count<2**ADDBITS: we=1, waddr=count[ADDBITS-1:0], wdata=din; count increments.
  - din_valid with count==2**ADDBITS: word dropped, overflow=1.
- ACQ exit:
  - readout_req with count>0 → RD_ADDR, ptr=0.
  - readout_req with count==0 → DONE.
  - din_valid together with readout_req: the word is written, is included in count, and is read out.
- RD_ADDR: rd=1, raddr=ptr. On the next edge: dout←rdata, dout_valid←1, rd←0, → RD_HOLD.
- RD_HOLD: dout_valid holds until dout_ready.
  - On handshake with ptr==count-1 → DONE.
  - Otherwise ptr++ and → RD_ADDR.
  - dout is stable while valid and not ready.
- DONE: done=1 for one cycle; count←0, overflow←0 → ACQ.
- din_valid in any state other than ACQ: dropped, overflow=1.
- rd and we are never asserted in the same cycle. we is 0 outside ACQ.
- Arithmetic: count is ADDBITS+1 bits and saturates at 2**ADDBITS; ptr is ADDBITS bits and never wraps.

## Timing
- All outputs are registered.
- Write: we/waddr/wdata are valid in the cycle after din_valid; the buffer latches on the following edge.
- Readout latency: readout_req edge → RD_ADDR next cycle → dout_valid the cycle after. First dout_valid is 2 cycles after readout_req is sampled.
- Throughput: one word per 2 cycles with dout_ready held high.
- done asserts the cycle after the final handshake.
- rst mid-readout: immediate return to ACQ, with count=0, dout_valid=0, rd=0, overflow=0. Buffer contents are abandoned.

## Configuration
- READOUT_HEADER_EN defined:
  - Before the data words, one header word is emitted: {8'hA5, count zero-extended/truncated to DATBITS-8}, with overflow in bit DATBITS-9 replacing the count MSB.
  - The header uses the same RD_HOLD handshake and has no buffer read.
  - With count==0 the header alone is emitted, then DONE.
  - Adds state HDR between ACQ and RD_ADDR.
- Undefined: data words only; count==0 readout goes straight to DONE with no dout_valid.

## Structure
- Shared package/include readout_pkg holds:
  - state encodings
  - header marker constant 8'hA5
  - default DATBITS/ADDBITS
- No sub-module; a single FSM plus count/ptr registers.

## Test plan
- Write 3 words 0x000011/22/33, then readout_req, dout_ready=1 → dout sequence 0x000011, 0x000022, 0x000033; done pulses; count returns to 0.
- Hold dout_ready=0 for 5 cycles on the second word → dout stays 0x000022 and dout_valid stays high; no raddr advance.
- Write 257 words with ADDBITS=8 → count=256, overflow=1; readout returns 256 words 0..255 in order; overflow clears at DONE.
- Assert rst during RD_HOLD of word 2 of 4 → all outputs 0 asynchronously; after release, state is ACQ and a new write lands at waddr=0.
- readout_req with count==0 → done pulse after 1 cycle, no dout_valid. With READOUT_HEADER_EN: exactly one dout 0xA50000, then done.
- din_valid during readout → not written (we stays 0), overflow=1; count after DONE is 0.
